// File: rtl/wbu_commit_queue_if.sv
// wbu_commit_queue_if
//   Groups the dispatch, write-back, commit and status signals of the
//   in-order commit queue.
//   slave  : the queue itself (takes alloc/wb/commit_ready/flush,
//            drives alloc_ready/alloc_tag/commit_*/occupancy/empty)
//   master : the surrounding core (dispatch, execute channels, consumer)
//   Parameters must match those of the wbu_commit_queue instance.
interface wbu_commit_queue_if #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2,
    parameter int DATA_W = 64,
    parameter int PC_W   = 64
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                     flush_flag;

    logic                     alloc_valid;
    logic                     alloc_ready;
    logic [PC_W-1:0]          alloc_pc;
    logic [4:0]               alloc_rd;
    logic                     alloc_dest_wen;
    logic [TAG_W-1:0]         alloc_tag;

    logic [NUM_WB-1:0]        wb_valid;
    logic [NUM_WB*TAG_W-1:0]  wb_tag;
    logic [NUM_WB*DATA_W-1:0] wb_data;
    logic [NUM_WB-1:0]        wb_trap;
    logic [NUM_WB*64-1:0]     wb_cause;

    logic                     commit_valid;
    logic                     commit_ready;
    logic [PC_W-1:0]          commit_pc;
    logic [4:0]               commit_rd;
    logic                     commit_dest_wen;
    logic [DATA_W-1:0]        commit_data;
    logic                     commit_trap;
    logic [63:0]              commit_cause;

    logic [TAG_W:0]           occupancy;
    logic                     empty;

    modport slave (
        input  flush_flag,
        input  alloc_valid, alloc_pc, alloc_rd, alloc_dest_wen,
        output alloc_ready, alloc_tag,
        input  wb_valid, wb_tag, wb_data, wb_trap, wb_cause,
        output commit_valid, commit_pc, commit_rd, commit_dest_wen,
        output commit_data, commit_trap, commit_cause,
        input  commit_ready,
        output occupancy, empty
    );

    modport master (
        output flush_flag,
        output alloc_valid, alloc_pc, alloc_rd, alloc_dest_wen,
        input  alloc_ready, alloc_tag,
        output wb_valid, wb_tag, wb_data, wb_trap, wb_cause,
        input  commit_valid, commit_pc, commit_rd, commit_dest_wen,
        input  commit_data, commit_trap, commit_cause,
        output commit_ready,
        input  occupancy, empty
    );
endinterface

// File: rtl/wbu_commit_queue.sv
// wbu_commit_queue
//   In-order commit buffer between the execute/LSU channels and the
//   GPR/CSR side. Dispatch allocates entries at the tail in program order,
//   NUM_WB write-back ports complete entries out of order, and the head
//   entry retires once complete. A trapping head commit or flush_flag
//   empties the whole buffer.
//   Ports:
//     clk   : core clock
//     rst_n : asynchronous active-low reset
//     bus   : wbu_commit_queue_if.slave (alloc, write-back, commit, status)
module wbu_commit_queue #(
    parameter int DEPTH  = 8,
    parameter int NUM_WB = 2,
    parameter int DATA_W = 64,
    parameter int PC_W   = 64
) (
    input logic               clk,
    input logic               rst_n,
    wbu_commit_queue_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);

    typedef logic [TAG_W:0]   ptr_t;
    typedef logic [TAG_W-1:0] tag_t;

    // Pointers carry an extra wrap bit to tell full from empty.
    ptr_t head;
    ptr_t tail;
    tag_t head_idx;
    tag_t tail_idx;

    logic full;
    logic alloc_fire;
    logic commit_fire;
    logic trap_flush;
    logic clear_all;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [DEPTH-1:0]  ent_trap;
    logic [DEPTH-1:0]  ent_dest_wen;
    logic [PC_W-1:0]   ent_pc    [DEPTH];
    logic [4:0]        ent_rd    [DEPTH];
    logic [DATA_W-1:0] ent_data  [DEPTH];
    logic [63:0]       ent_cause [DEPTH];

    tag_t              port_tag   [NUM_WB];
    logic [DATA_W-1:0] port_data  [NUM_WB];
    logic [63:0]       port_cause [NUM_WB];
    logic [NUM_WB-1:0] wb_en;

    for (genvar p = 0; p < NUM_WB; p++) begin : g_port
        assign port_tag[p]   = bus.wb_tag[p*TAG_W +: TAG_W];
        assign port_data[p]  = bus.wb_data[p*DATA_W +: DATA_W];
        assign port_cause[p] = bus.wb_cause[p*64 +: 64];
    end

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];
    assign full     = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

    assign bus.alloc_ready = !full && !bus.flush_flag;
    assign bus.alloc_tag   = tail_idx;
    assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

    assign bus.commit_valid    = ent_valid[head_idx] && ent_done[head_idx] && !bus.flush_flag;
    assign bus.commit_pc       = ent_pc[head_idx];
    assign bus.commit_rd       = ent_rd[head_idx];
    assign bus.commit_dest_wen = ent_dest_wen[head_idx] && !ent_trap[head_idx];
    assign bus.commit_data     = ent_data[head_idx];
    assign bus.commit_trap     = ent_trap[head_idx];
    assign bus.commit_cause    = ent_cause[head_idx];
    assign commit_fire         = bus.commit_valid && bus.commit_ready;

    // A trapping entry leaving the head discards everything behind it.
    assign trap_flush = commit_fire && ent_trap[head_idx];
    assign clear_all  = bus.flush_flag || trap_flush;

    assign bus.occupancy = tail - head;
    assign bus.empty     = (head == tail);

    // Per-port write enable: target must be a live entry, and a lower port
    // hitting the same tag this cycle suppresses the higher one, so at most
    // one port ever writes a given entry.
    always_comb begin
        wb_en = '0;
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            wb_en[i] = bus.wb_valid[i] && ent_valid[port_tag[i]] && !bus.flush_flag;
            for (int unsigned j = 0; j < i; j++) begin
                if (bus.wb_valid[j] && (port_tag[j] == port_tag[i])) begin
                    wb_en[i] = 1'b0;
                end
            end
        end
    end

    // Control state: pointers and per-entry status bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_trap  <= '0;
        end else if (clear_all) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
            ent_trap  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_WB; i++) begin
                if (wb_en[i]) begin
                    ent_done[port_tag[i]] <= 1'b1;
                    ent_trap[port_tag[i]] <= bus.wb_trap[i];
                end
            end
            if (commit_fire) begin
                ent_valid[head_idx] <= 1'b0;
                head                <= head + ptr_t'(1);
            end
            // The tail slot is never live when allocation is allowed, so this
            // cannot collide with the write-back or commit updates above.
            if (alloc_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                ent_trap[tail_idx]  <= 1'b0;
                tail                <= tail + ptr_t'(1);
            end
        end
    end

    // Payload storage; only meaningful while the entry is valid.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_pc[tail_idx]       <= bus.alloc_pc;
            ent_rd[tail_idx]       <= bus.alloc_rd;
            ent_dest_wen[tail_idx] <= bus.alloc_dest_wen;
        end
        for (int unsigned i = 0; i < NUM_WB; i++) begin
            if (wb_en[i]) begin
                ent_data[port_tag[i]]  <= port_data[i];
                ent_cause[port_tag[i]] <= port_cause[i];
            end
        end
    end
endmodule

// File: tb/tb_wbu_commit_queue.sv
// tb_wbu_commit_queue
//   Directed bench for wbu_commit_queue (DEPTH=8, NUM_WB=2): a vector table
//   for out-of-order completion and port collision, then hand-written
//   sequences for full/wrap, trap at head, external flush and async reset.
module tb_wbu_commit_queue;
    localparam int DEPTH  = 8;
    localparam int NUM_WB = 2;
    localparam int DATA_W = 64;
    localparam int PC_W   = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    wbu_commit_queue_if #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .DATA_W(DATA_W), .PC_W(PC_W)) bus ();

    wbu_commit_queue #(.DEPTH(DEPTH), .NUM_WB(NUM_WB), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        av;
        logic [4:0]  rd;
        logic [1:0]  wbv;
        logic [2:0]  t0;
        logic [2:0]  t1;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        cr;
        logic        e_ar;
        logic [2:0]  e_tag;
        logic        e_cv;
        logic [4:0]  e_rd;
        logic [63:0] e_data;
        logic [3:0]  e_occ;
    } vec_t;

    vec_t vt[20];
    int   nvec;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic av, input logic [4:0] rd,
                       input logic [1:0] wbv, input logic [2:0] t0, input logic [2:0] t1,
                       input logic [63:0] d0, input logic [63:0] d1, input logic cr,
                       input logic e_ar, input logic [2:0] e_tag, input logic e_cv,
                       input logic [4:0] e_rd, input logic [63:0] e_data, input logic [3:0] e_occ);
        vt[nvec] = '{fl, av, rd, wbv, t0, t1, d0, d1, cr, e_ar, e_tag, e_cv, e_rd, e_data, e_occ};
        nvec++;
    endtask

    task automatic idle();
        bus.flush_flag     = 1'b0;
        bus.alloc_valid    = 1'b0;
        bus.alloc_pc       = '0;
        bus.alloc_rd       = '0;
        bus.alloc_dest_wen = 1'b0;
        bus.wb_valid       = '0;
        bus.wb_tag         = '0;
        bus.wb_data        = '0;
        bus.wb_trap        = '0;
        bus.wb_cause       = '0;
        bus.commit_ready   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alloc(input logic [4:0] rd);
        bus.alloc_valid    = 1'b1;
        bus.alloc_rd       = rd;
        bus.alloc_pc       = 64'h1000 + 64'(rd) * 4;
        bus.alloc_dest_wen = 1'b1;
    endtask

    task automatic drive_wb0(input logic [2:0] tag, input logic [63:0] data,
                             input logic trap, input logic [63:0] cause);
        bus.wb_valid[0]     = 1'b1;
        bus.wb_tag[2:0]     = tag;
        bus.wb_data[63:0]   = data;
        bus.wb_trap[0]      = trap;
        bus.wb_cause[63:0]  = cause;
    endtask

    task automatic drive_wb1(input logic [2:0] tag, input logic [63:0] data);
        bus.wb_valid[1]      = 1'b1;
        bus.wb_tag[5:3]      = tag;
        bus.wb_data[127:64]  = data;
        bus.wb_trap[1]       = 1'b0;
        bus.wb_cause[127:64] = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nvec     = 0;
        rst_n    = 1'b0;
        idle();

        // ---- reset state ----
        #12;
        chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("rst_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---- vector table: out-of-order completion, then port collision ----
        //   fl av rd wbv  t0 t1 d0     d1     cr | ar tag cv rd data   occ
        add(0, 1, 5, 2'b00, 0, 0, 0,     0,     0,  1, 0, 0, 0, 0,     0);
        add(0, 1, 6, 2'b00, 0, 0, 0,     0,     0,  1, 1, 0, 0, 0,     1);
        add(0, 1, 7, 2'b00, 0, 0, 0,     0,     0,  1, 2, 0, 0, 0,     2);
        add(0, 0, 0, 2'b10, 0, 2, 0,     'h33,  0,  1, 3, 0, 0, 0,     3);
        add(0, 0, 0, 2'b01, 0, 0, 'h11,  0,     1,  1, 3, 0, 0, 0,     3);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     1,  1, 3, 1, 5, 'h11,  3);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     1,  1, 3, 0, 0, 0,     2);
        add(0, 0, 0, 2'b01, 1, 0, 'h22,  0,     1,  1, 3, 0, 0, 0,     2);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     1,  1, 3, 1, 6, 'h22,  2);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     1,  1, 3, 1, 7, 'h33,  1);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     0,  1, 3, 0, 0, 0,     0);
        add(0, 1, 9, 2'b00, 0, 0, 0,     0,     0,  1, 3, 0, 0, 0,     0);
        add(0, 0, 0, 2'b11, 3, 3, 'hAA,  'hBB,  0,  1, 4, 0, 0, 0,     1);
        add(0, 0, 0, 2'b10, 0, 6, 0,     'h66,  0,  1, 4, 1, 9, 'hAA,  1);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     1,  1, 4, 1, 9, 'hAA,  1);
        add(0, 0, 0, 2'b00, 0, 0, 0,     0,     0,  1, 4, 0, 0, 0,     0);

        for (int k = 0; k < nvec; k++) begin
            idle();
            bus.flush_flag = vt[k].fl;
            if (vt[k].av) drive_alloc(vt[k].rd);
            bus.wb_valid     = vt[k].wbv;
            bus.wb_tag       = {vt[k].t1, vt[k].t0};
            bus.wb_data      = {vt[k].d1, vt[k].d0};
            bus.commit_ready = vt[k].cr;
            @(negedge clk);
            chk($sformatf("v%0d_alloc_ready", k), 64'(bus.alloc_ready), 64'(vt[k].e_ar));
            chk($sformatf("v%0d_alloc_tag", k), 64'(bus.alloc_tag), 64'(vt[k].e_tag));
            chk($sformatf("v%0d_commit_valid", k), 64'(bus.commit_valid), 64'(vt[k].e_cv));
            chk($sformatf("v%0d_occupancy", k), 64'(bus.occupancy), 64'(vt[k].e_occ));
            if (vt[k].e_cv) begin
                chk($sformatf("v%0d_commit_rd", k), 64'(bus.commit_rd), 64'(vt[k].e_rd));
                chk($sformatf("v%0d_commit_data", k), bus.commit_data, vt[k].e_data);
            end
            step();
        end

        // ---- full and wrap ----
        idle();
        bus.flush_flag = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            idle();
            drive_alloc(5'(i));
            @(negedge clk);
            chk($sformatf("fill_tag%0d", i), 64'(bus.alloc_tag), 64'(i));
            step();
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            drive_alloc(5'd31);
            drive_wb0(3'(2*k), 64'h100 + 64'(2*k), 1'b0, '0);
            drive_wb1(3'(2*k+1), 64'h100 + 64'(2*k+1));
            @(negedge clk);
            if (k == 0) begin
                chk("full_alloc_ready", 64'(bus.alloc_ready), 64'd0);
                chk("full_occupancy", 64'(bus.occupancy), 64'd8);
            end
            step();
        end
        // commit seq 0 while alloc held: still full this cycle
        idle();
        drive_alloc(5'd8);
        bus.commit_ready = 1'b1;
        @(negedge clk);
        chk("wrap_ready_same_cycle", 64'(bus.alloc_ready), 64'd0);
        chk("wrap_commit_rd0", 64'(bus.commit_rd), 64'd0);
        step();
        // slot freed: seq 8 allocates at tag 0 on the next lap, seq 1 commits
        @(negedge clk);
        chk("wrap_alloc_ready", 64'(bus.alloc_ready), 64'd1);
        chk("wrap_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        chk("wrap_occupancy", 64'(bus.occupancy), 64'd7);
        chk("wrap_commit_rd1", 64'(bus.commit_rd), 64'd1);
        step();
        for (int m = 0; m < 20; m++) begin
            idle();
            drive_alloc(5'(9 + m));
            bus.commit_ready = 1'b1;
            drive_wb0(3'(8 + m), 64'h100 + 64'(8 + m), 1'b0, '0);
            @(negedge clk);
            chk($sformatf("pair%0d_alloc_tag", m), 64'(bus.alloc_tag), 64'((9 + m) % 8));
            chk($sformatf("pair%0d_commit_valid", m), 64'(bus.commit_valid), 64'd1);
            chk($sformatf("pair%0d_commit_rd", m), 64'(bus.commit_rd), 64'(2 + m));
            chk($sformatf("pair%0d_commit_data", m), bus.commit_data, 64'h100 + 64'(2 + m));
            step();
        end
        idle();
        @(negedge clk);
        chk("pairs_occupancy", 64'(bus.occupancy), 64'd7);
        bus.flush_flag = 1'b1;
        step();

        // ---- trap at head ----
        for (int i = 0; i < 4; i++) begin
            idle();
            drive_alloc(5'(i + 1));
            step();
        end
        idle();
        drive_wb0(3'd0, 64'hDEAD, 1'b1, 64'd2);
        step();
        idle();
        bus.commit_ready = 1'b1;
        @(negedge clk);
        chk("trap_commit_valid", 64'(bus.commit_valid), 64'd1);
        chk("trap_commit_trap", 64'(bus.commit_trap), 64'd1);
        chk("trap_commit_cause", bus.commit_cause, 64'd2);
        chk("trap_commit_dest_wen", 64'(bus.commit_dest_wen), 64'd0);
        chk("trap_commit_rd", 64'(bus.commit_rd), 64'd1);
        step();
        idle();
        @(negedge clk);
        chk("trap_after_empty", 64'(bus.empty), 64'd1);
        chk("trap_after_occupancy", 64'(bus.occupancy), 64'd0);
        drive_wb0(3'd1, 64'h1, 1'b0, '0);
        drive_wb1(3'd2, 64'h2);
        step();
        idle();
        drive_wb0(3'd3, 64'h3, 1'b0, '0);
        step();
        idle();
        @(negedge clk);
        chk("trap_late_wb_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("trap_late_wb_occupancy", 64'(bus.occupancy), 64'd0);
        chk("trap_late_wb_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        step();

        // ---- external flush during activity ----
        idle();
        drive_alloc(5'd10);
        step();
        idle();
        drive_alloc(5'd11);
        step();
        idle();
        drive_wb0(3'd0, 64'h55, 1'b0, '0);
        step();
        idle();
        bus.flush_flag = 1'b1;
        drive_alloc(5'd12);
        drive_wb0(3'd1, 64'h66, 1'b0, '0);
        drive_wb1(3'd0, 64'h77);
        bus.commit_ready = 1'b1;
        @(negedge clk);
        chk("flush_commit_valid", 64'(bus.commit_valid), 64'd0);
        chk("flush_alloc_ready", 64'(bus.alloc_ready), 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("flush_after_occupancy", 64'(bus.occupancy), 64'd0);
        chk("flush_after_empty", 64'(bus.empty), 64'd1);
        chk("flush_after_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        chk("flush_after_commit_valid", 64'(bus.commit_valid), 64'd0);
        drive_alloc(5'd12);
        step();
        idle();
        drive_alloc(5'd13);
        @(negedge clk);
        chk("post_flush_alloc_tag", 64'(bus.alloc_tag), 64'd1);
        chk("post_flush_commit_valid", 64'(bus.commit_valid), 64'd0);
        step();
        idle();
        @(negedge clk);
        chk("pre_reset_occupancy", 64'(bus.occupancy), 64'd2);

        // ---- asynchronous reset mid-operation ----
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_occupancy", 64'(bus.occupancy), 64'd0);
        chk("async_rst_empty", 64'(bus.empty), 64'd1);
        chk("async_rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
